// File: rtl/apb_nslave_master.sv
// rtl/apb_nslave_master.sv - APB master bridge driving NUM_SLAVES slaves with waits, errors and timeout
module apb_nslave_master #(
    parameter int AW         = 9,
    parameter int DW         = 8,
    parameter int NUM_SLAVES = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     transfer,
    input  logic                     read_write,
    input  logic [AW-1:0]            apb_write_paddr,
    input  logic [DW-1:0]            apb_write_data,
    input  logic [AW-1:0]            apb_read_paddr,
    output logic                     req_ready,
    output logic [DW-1:0]            apb_read_data_out,
    output logic                     rsp_valid,
    output logic                     rsp_error,
    output logic [NUM_SLAVES-1:0]    psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [AW-1:0]            paddr,
    output logic [DW-1:0]            pwdata,
    input  logic [NUM_SLAVES*DW-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]    pready,
    input  logic [NUM_SLAVES-1:0]    pslverr
);

    // Slave-select width is derived, never overridden; at least one bit.
    localparam int SW = (NUM_SLAVES <= 2) ? 1 : $clog2(NUM_SLAVES);
    // Wait counter must be able to hold TIMEOUT; keep one bit when disabled.
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DECERR
    } state_t;

    state_t                  state_q;
    logic [SW-1:0]           idx_q;
    logic [CW-1:0]           wait_q;
    logic                    req_ready_q;
    logic [DW-1:0]           rdata_q;
    logic                    rsp_valid_q;
    logic                    rsp_error_q;
    logic [NUM_SLAVES-1:0]   psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [AW-1:0]           paddr_q;
    logic [DW-1:0]           pwdata_q;

    logic [AW-1:0]           addr_d;
    logic [SW-1:0]           idx_d;
    logic [NUM_SLAVES-1:0]   onehot_d;
    logic [CW-1:0]           wait_d;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DW-1:0]           sel_rdata;
    logic                    timeout_hit;

    // Request decode and selected-slave response mux; other slaves are never looked at.
    always_comb begin
        addr_d    = read_write ? apb_read_paddr : apb_write_paddr;
        idx_d     = addr_d[AW-1 -: SW];
        onehot_d  = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            onehot_d[i] = (idx_d == SW'(i));
            if (idx_q == SW'(i)) begin
                sel_ready = pready[i];
                sel_err   = pslverr[i];
                sel_rdata = prdata[i*DW +: DW];
            end
        end
        wait_d      = wait_q + 1'b1;
        timeout_hit = (TIMEOUT != 0) && (wait_d == CW'(TIMEOUT));
    end

    // Transfer sequencer with all bus and response outputs registered.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            wait_q      <= '0;
            req_ready_q <= 1'b1;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (transfer) begin
                        paddr_q     <= addr_d;
                        pwdata_q    <= apb_write_data;
                        pwrite_q    <= !read_write;
                        idx_q       <= idx_d;
                        wait_q      <= '0;
                        req_ready_q <= 1'b0;
                        // An index past the populated slaves selects nobody.
                        if (|onehot_d) begin
                            psel_q  <= onehot_d;
                            state_q <= ST_SETUP;
                        end else begin
                            state_q <= ST_DECERR;
                        end
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= sel_err;
                        req_ready_q <= 1'b1;
                        // Read data is returned even alongside a slave error.
                        if (!pwrite_q) begin
                            rdata_q <= sel_rdata;
                        end
                        state_q     <= ST_IDLE;
                    end else if (timeout_hit) begin
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                ST_DECERR: begin
                    rsp_valid_q <= 1'b1;
                    rsp_error_q <= 1'b1;
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready         = req_ready_q;
    assign apb_read_data_out = rdata_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_error         = rsp_error_q;
    assign psel              = psel_q;
    assign penable           = penable_q;
    assign pwrite            = pwrite_q;
    assign paddr             = paddr_q;
    assign pwdata            = pwdata_q;

endmodule

// File: tb/tb_apb_nslave_master.sv
// tb/tb_apb_nslave_master.sv - self-checking bench for apb_nslave_master
module tb_apb_nslave_master;

    localparam int AW  = 9;
    localparam int DW  = 8;
    localparam int NS  = 4;
    localparam int TO  = 4;
    localparam int NSB = 3;

    logic pclk   = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    logic          transfer   = 1'b0;
    logic          transfer_b = 1'b0;
    logic          read_write = 1'b0;
    logic [AW-1:0] wr_addr    = '0;
    logic [AW-1:0] rd_addr    = '0;
    logic [DW-1:0] wr_data    = '0;

    logic             req_ready, rsp_valid, rsp_error, penable, pwrite;
    logic [DW-1:0]    rdata_out, pwdata;
    logic [AW-1:0]    paddr;
    logic [NS-1:0]    psel, pready, pslverr;
    logic [NS*DW-1:0] prdata;

    logic              req_ready_b, rsp_valid_b, rsp_error_b, penable_b, pwrite_b;
    logic [DW-1:0]     rdata_out_b, pwdata_b;
    logic [AW-1:0]     paddr_b;
    logic [NSB-1:0]    psel_b;
    logic [NSB-1:0]    pready_b  = 3'b111;
    logic [NSB-1:0]    pslverr_b = 3'b000;
    logic [NSB*DW-1:0] prdata_b  = {8'h33, 8'h22, 8'h11};

    apb_nslave_master #(.AW(AW), .DW(DW), .NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
        .pclk(pclk), .preset(preset), .transfer(transfer), .read_write(read_write),
        .apb_write_paddr(wr_addr), .apb_write_data(wr_data), .apb_read_paddr(rd_addr),
        .req_ready(req_ready), .apb_read_data_out(rdata_out), .rsp_valid(rsp_valid),
        .rsp_error(rsp_error), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb_nslave_master #(.AW(AW), .DW(DW), .NUM_SLAVES(NSB), .TIMEOUT(16)) dut_b (
        .pclk(pclk), .preset(preset), .transfer(transfer_b), .read_write(read_write),
        .apb_write_paddr(wr_addr), .apb_write_data(wr_data), .apb_read_paddr(rd_addr),
        .req_ready(req_ready_b), .apb_read_data_out(rdata_out_b), .rsp_valid(rsp_valid_b),
        .rsp_error(rsp_error_b), .psel(psel_b), .penable(penable_b), .pwrite(pwrite_b),
        .paddr(paddr_b), .pwdata(pwdata_b), .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave array: selected slave raises pready after wait_cfg ACCESS cycles;
    // unselected slaves drive pready/pslverr high as noise.
    int            wait_cfg [NS];
    logic [NS-1:0] err_cfg = '0;
    logic [DW-1:0] rd_cfg   [NS];
    int            acc_cnt = 0;

    always @(posedge pclk) acc_cnt <= penable ? acc_cnt + 1 : 0;

    always_comb begin
        pready  = '0;
        pslverr = '0;
        prdata  = '0;
        for (int i = 0; i < NS; i++) begin
            pready[i]           = psel[i] ? (penable && (acc_cnt >= wait_cfg[i])) : 1'b1;
            pslverr[i]          = psel[i] ? err_cfg[i] : 1'b1;
            prdata[i*DW +: DW]  = rd_cfg[i];
        end
    end

    // Transaction-level model: age counts cycles into the current transfer.
    logic          m_busy, m_rr, m_rv, m_re, m_pen, m_pwrite;
    int            m_age, m_waits, m_idx;
    logic [NS-1:0] m_psel;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata, m_rdata;

    always @(posedge pclk or posedge preset) begin : model
        logic [AW-1:0] a;
        int            ix;
        if (preset) begin
            m_busy <= 1'b0; m_rr <= 1'b1; m_rv <= 1'b0; m_re <= 1'b0; m_pen <= 1'b0;
            m_pwrite <= 1'b0; m_age <= 0; m_waits <= 0; m_idx <= 0; m_psel <= '0;
            m_paddr <= '0; m_pwdata <= '0; m_rdata <= '0;
        end else begin
            m_rv <= 1'b0;
            if (!m_busy) begin
                if (transfer) begin
                    a  = read_write ? rd_addr : wr_addr;
                    ix = int'(a >> (AW - 2));
                    m_paddr  <= a;
                    m_pwdata <= wr_data;
                    m_pwrite <= !read_write;
                    m_idx    <= ix;
                    m_busy   <= 1'b1;
                    m_age    <= 1;
                    m_waits  <= 0;
                    m_rr     <= 1'b0;
                    m_psel   <= (ix < NS) ? NS'(1 << ix) : '0;
                end
            end else if (m_age == 1) begin
                m_age <= 2;
                m_pen <= 1'b1;
            end else if (pready[m_idx] || (TO != 0 && m_waits + 1 == TO)) begin
                m_busy <= 1'b0;
                m_rr   <= 1'b1;
                m_rv   <= 1'b1;
                m_pen  <= 1'b0;
                m_psel <= '0;
                m_re   <= pready[m_idx] ? pslverr[m_idx] : 1'b1;
                if (pready[m_idx] && !m_pwrite) m_rdata <= prdata[m_idx*DW +: DW];
            end else begin
                m_waits <= m_waits + 1;
            end
        end
    end

    logic cmp_en = 1'b0;

    // Every-cycle comparison of DUT A against the model.
    always @(negedge pclk) begin
        if (cmp_en) begin
            chk("cmp_req_ready", 32'(req_ready), 32'(m_rr));
            chk("cmp_rsp_valid", 32'(rsp_valid), 32'(m_rv));
            if (m_rv) chk("cmp_rsp_error", 32'(rsp_error), 32'(m_re));
            chk("cmp_psel", 32'(psel), 32'(m_psel));
            chk("cmp_penable", 32'(penable), 32'(m_pen));
            chk("cmp_pwrite", 32'(pwrite), 32'(m_pwrite));
            chk("cmp_paddr", 32'(paddr), 32'(m_paddr));
            chk("cmp_pwdata", 32'(pwdata), 32'(m_pwdata));
            chk("cmp_rdata", 32'(rdata_out), 32'(m_rdata));
        end
    end

    int            r_lat, r_pen, r_sel;
    logic          r_err, r_pwrite1, r_rr1;
    logic [NS-1:0] r_psel1;
    logic [DW-1:0] r_pwdata1;
    logic [AW-1:0] r_paddr1;

    task automatic do_xfer(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(negedge pclk);
        transfer   = 1'b1;
        read_write = rw;
        rd_addr    = rw ? addr : ~addr;
        wr_addr    = rw ? ~addr : addr;
        wr_data    = data;
        @(posedge pclk);
        r_lat = -1; r_pen = 0; r_sel = 0; r_err = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge pclk);
            if (k == 1) begin
                transfer  = 1'b0;
                r_psel1   = psel;
                r_pwrite1 = pwrite;
                r_pwdata1 = pwdata;
                r_paddr1  = paddr;
            end
            if (penable) r_pen++;
            if (psel != '0) r_sel++;
            if (rsp_valid) begin
                r_lat = k;
                r_err = rsp_error;
                break;
            end
        end
    endtask

    task automatic do_xfer_b(input logic rw, input logic [AW-1:0] addr);
        @(negedge pclk);
        transfer_b = 1'b1;
        read_write = rw;
        rd_addr    = addr;
        wr_addr    = addr;
        wr_data    = 8'hE1;
        @(posedge pclk);
        r_lat = -1; r_sel = 0; r_err = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge pclk);
            if (k == 1) begin
                transfer_b = 1'b0;
                r_rr1      = req_ready_b;
            end
            if (psel_b != '0) r_sel++;
            if (rsp_valid_b) begin
                r_lat = k;
                r_err = rsp_error_b;
                break;
            end
        end
    endtask

    int t_rsp [2];
    int n_rsp;

    initial begin
        for (int i = 0; i < NS; i++) wait_cfg[i] = 0;
        rd_cfg[0] = 8'h0F; rd_cfg[1] = 8'h77; rd_cfg[2] = 8'h3C; rd_cfg[3] = 8'hC3;
        repeat (2) @(negedge pclk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rdata_out), 32'd0);
        cmp_en = 1'b1;
        preset = 1'b0;
        @(negedge pclk);

        // 1: zero-wait write to slave 0
        do_xfer(1'b0, 9'h005, 8'hA5);
        chk("t1_latency", 32'(r_lat), 32'd3);
        chk("t1_err", 32'(r_err), 32'd0);
        chk("t1_psel_cycles", 32'(r_sel), 32'd2);
        chk("t1_penable_cycles", 32'(r_pen), 32'd1);
        chk("t1_psel", 32'(r_psel1), 32'h1);
        chk("t1_pwrite", 32'(r_pwrite1), 32'd1);
        chk("t1_pwdata", 32'(r_pwdata1), 32'hA5);
        chk("t1_rdata", 32'(rdata_out), 32'h00);

        // 2: read slave 2 with two wait states
        wait_cfg[2] = 2;
        do_xfer(1'b1, 9'h10F, 8'h00);
        chk("t2_latency", 32'(r_lat), 32'd5);
        chk("t2_penable_cycles", 32'(r_pen), 32'd3);
        chk("t2_psel", 32'(r_psel1), 32'h4);
        chk("t2_paddr", 32'(r_paddr1), 32'h10F);
        chk("t2_err", 32'(r_err), 32'd0);
        chk("t2_rdata", 32'(rdata_out), 32'h3C);
        wait_cfg[2] = 0;

        // 3: slave error on write, then on read
        err_cfg[1] = 1'b1;
        do_xfer(1'b0, 9'h0A0, 8'h96);
        chk("t3_latency", 32'(r_lat), 32'd3);
        chk("t3_err", 32'(r_err), 32'd1);
        chk("t3_rdata_kept", 32'(rdata_out), 32'h3C);
        do_xfer(1'b1, 9'h0A0, 8'h00);
        chk("t3r_err", 32'(r_err), 32'd1);
        chk("t3r_rdata", 32'(rdata_out), 32'h77);
        err_cfg[1] = 1'b0;

        // 5: timeout on slave 3, then a normal transfer
        wait_cfg[3] = 1000;
        do_xfer(1'b1, 9'h180, 8'h00);
        chk("t5_latency", 32'(r_lat), 32'd6);
        chk("t5_penable_cycles", 32'(r_pen), 32'd4);
        chk("t5_err", 32'(r_err), 32'd1);
        chk("t5_rdata_kept", 32'(rdata_out), 32'h77);
        chk("t5_psel_off", 32'(psel), 32'd0);
        wait_cfg[3] = 0;
        do_xfer(1'b0, 9'h1FF, 8'h42);
        chk("t5n_latency", 32'(r_lat), 32'd3);
        chk("t5n_err", 32'(r_err), 32'd0);

        // 6: asynchronous reset during a wait state
        wait_cfg[1] = 1000;
        @(negedge pclk);
        transfer = 1'b1; read_write = 1'b1; rd_addr = 9'h0C3;
        @(posedge pclk);
        @(negedge pclk);
        transfer = 1'b0;
        repeat (2) @(negedge pclk);
        chk("t6_in_access", 32'(penable), 32'd1);
        #2 preset = 1'b1;
        #1;
        chk("t6_psel", 32'(psel), 32'd0);
        chk("t6_penable", 32'(penable), 32'd0);
        chk("t6_req_ready", 32'(req_ready), 32'd1);
        chk("t6_paddr", 32'(paddr), 32'd0);
        chk("t6_rdata", 32'(rdata_out), 32'd0);
        @(negedge pclk);
        preset = 1'b0;
        wait_cfg[1] = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge pclk);
            chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // 7: back-to-back with transfer held high
        @(negedge pclk);
        transfer = 1'b1; read_write = 1'b0; wr_addr = 9'h011; wr_data = 8'h5A; rd_addr = 9'h000;
        @(posedge pclk);
        n_rsp = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge pclk);
            if (k == 1) begin
                read_write = 1'b1; rd_addr = 9'h1A2; wr_addr = 9'h0FF;
            end
            chk("t7_onehot", 32'($countones(psel) <= 1), 32'd1);
            if (rsp_valid && n_rsp < 2) begin
                t_rsp[n_rsp] = k;
                n_rsp++;
                chk("t7_err", 32'(rsp_error), 32'd0);
            end
            if (n_rsp == 1 && k == t_rsp[0] + 1) transfer = 1'b0;
        end
        transfer = 1'b0;
        chk("t7_count", 32'(n_rsp), 32'd2);
        chk("t7_first", 32'(t_rsp[0]), 32'd3);
        chk("t7_second", 32'(t_rsp[1]), 32'd6);
        chk("t7_rdata", 32'(rdata_out), 32'hC3);

        // 4: decode error on the three-slave instance
        do_xfer_b(1'b0, 9'h1C0);
        chk("t4_latency", 32'(r_lat), 32'd2);
        chk("t4_err", 32'(r_err), 32'd1);
        chk("t4_psel_cycles", 32'(r_sel), 32'd0);
        chk("t4_req_ready", 32'(r_rr1), 32'd0);
        do_xfer_b(1'b1, 9'h105);
        chk("t4n_latency", 32'(r_lat), 32'd3);
        chk("t4n_err", 32'(r_err), 32'd0);
        chk("t4n_psel_cycles", 32'(r_sel), 32'd2);
        chk("t4n_rdata", 32'(rdata_out_b), 32'h33);

        repeat (2) @(negedge pclk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/apb_nslave_master.md
Name: apb_nslave_master

Overview:
Parametrised APB master bridge. It is the successor to the fixed two-slave bridge and drives NUM_SLAVES APB slaves from the existing transfer/read_write request interface. Additions over the two-slave bridge:
- per-slave wait-state support (pready)
- error reporting (pslverr, bad decode, timeout)
- an explicit request/response handshake

It sits between the testbench/user driver and the slave array.

Parameters:
AW, 9, address width; the top SW bits select the slave.
DW, 8, data width.
NUM_SLAVES, 4, number of APB slaves (2..16).
SW, $clog2(NUM_SLAVES) (min 1), derived slave-select width; not overridable.
TIMEOUT, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
pclk  in  1  APB clock, all logic on its rising edge.
preset  in  1  asynchronous, active-high reset.
transfer  in  1  request valid.
read_write  in  1  1 = read, 0 = write.
apb_write_paddr  in  AW  write address.
apb_write_data  in  DW  write data.
apb_read_paddr  in  AW  read address.
req_ready  out  1  bridge can accept a request (IDLE only).
apb_read_data_out  out  DW  read data of the last completed read.
rsp_valid  out  1  one-cycle completion pulse.
rsp_error  out  1  error flag, valid while rsp_valid=1.
psel  out  NUM_SLAVES  one-hot slave select.
penable  out  1  APB enable.
pwrite  out  1  APB direction.
paddr  out  AW  APB address.
pwdata  out  DW  APB write data.
prdata  in  NUM_SLAVES*DW  slave read data, slave i at [i*DW +: DW].
pready  in  NUM_SLAVES  per-slave ready.
pslverr  in  NUM_SLAVES  per-slave error.

Behaviour:
- States: IDLE, SETUP, ACCESS, DECERR. All outputs are registered.
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, apb_read_data_out=0, rsp_valid=0, rsp_error=0, req_ready=1.
  - The wait counter is cleared.
  - An in-flight transfer is dropped with no response.
- Request acceptance, IDLE with transfer=1:
  - Capture addr = read_write ? apb_read_paddr : apb_write_paddr.
  - Capture pwdata = apb_write_data and pwrite = !read_write.
  - Compute idx = addr[AW-1 -: SW].
  - req_ready drops the following cycle.
  - If idx < NUM_SLAVES, go to SETUP; otherwise go to DECERR.
- SETUP (1 cycle): psel[idx]=1, penable=0, paddr/pwrite/pwdata valid. Then go to ACCESS.
- ACCESS: psel[idx]=1, penable=1. Address, data and direction are held stable throughout.
  - pready[idx]=1: transfer completes at this edge.
    - psel and penable go to 0; state returns to IDLE.
    - rsp_valid=1 for exactly the next cycle, with rsp_error=pslverr[idx].
    - On a read, apb_read_data_out = prdata[idx], captured even when pslverr is set. On a write, apb_read_data_out is unchanged.
  - pready[idx]=0: wait counter increments.
    - If TIMEOUT!=0 and the counter reaches TIMEOUT: abort. psel/penable go to 0, state returns to IDLE, rsp_valid=1 with rsp_error=1, apb_read_data_out is unchanged.
- DECERR (1 cycle): no psel asserted. Next cycle rsp_valid=1, rsp_error=1, then IDLE.
- Only pready/pslverr/prdata of the selected slave are observed; other slaves' inputs are ignored.
- The wait counter is $clog2(TIMEOUT+1) bits and clears on entry to SETUP.
- Latency from acceptance edge to rsp_valid:
  - zero-wait: 3 cycles
  - N wait states: 3+N cycles
  - decode error: 2 cycles
- Back-to-back: req_ready=1 in the same cycle rsp_valid=1. If transfer is held high, the next SETUP starts the cycle after. Minimum spacing is 3 cycles per transfer.
- Idle bus: paddr/pwrite/pwdata hold their last values; psel=0, penable=0.
- transfer=0 in IDLE: no state change. transfer is ignored outside IDLE.

Test Plan:
1. Zero-wait write: write addr 0x005 (slave 0), data 0xA5, pready[0]=1.
   -> psel=0001 for 2 cycles, penable=1 in the 2nd cycle, pwrite=1, pwdata=0xA5; rsp_valid 3 cycles after accept, rsp_error=0.
2. Read with waits: read addr 0x10F (slave 2), pready[2] low for 2 ACCESS cycles, prdata slice 2 = 0x3C.
   -> penable high for 3 cycles; apb_read_data_out=0x3C; rsp_valid 5 cycles after accept.
3. Slave error: pslverr[1]=1 with pready[1]=1 on a write to slave 1.
   -> rsp_valid=1, rsp_error=1, apb_read_data_out unchanged.
4. Decode error: NUM_SLAVES=3, request to addr 0x1C0 (idx 3).
   -> no psel ever asserted; rsp_valid=1, rsp_error=1 2 cycles after accept.
5. Timeout: TIMEOUT=4, pready held 0.
   -> abort after 4 ACCESS wait cycles; psel=0, rsp_error=1; the next request is accepted normally.
6. Reset mid-ACCESS: assert preset between edges during a wait state.
   -> all outputs reset immediately (asynchronously); no rsp_valid afterwards.
7. After release, back-to-back with transfer held high: write slave 0, then read slave 3.
   -> responses 3 cycles apart, psel never overlapping.
